// File: rtl/mat_cop_scheduler_pkg.sv
// rtl/mat_cop_scheduler_pkg.sv - shared constants for the matrix coprocessor scheduler
package mat_cop_scheduler_pkg;

  localparam int OPC_BIT         = 8;
  localparam int TIMEOUT_CYC_DEF = 1024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  // grant is one-hot {dbg, cpu}; maps to the owner encoding
  function automatic logic owner_of(input logic [1:0] grant);
    return grant[1] ? OWNER_DBG : OWNER_CPU;
  endfunction

endpackage

// File: rtl/mat_cop_scheduler_if.sv
// rtl/mat_cop_scheduler_if.sv - request, coprocessor and result signals of the scheduler
interface mat_cop_scheduler_if
  import mat_cop_scheduler_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = OPC_BIT
);
  logic              cpu_req_valid;
  logic [OP_W-1:0]   cpu_req_op;
  logic [DATA_W-1:0] cpu_req_a;
  logic [DATA_W-1:0] cpu_req_b;
  logic              cpu_req_ready;

  logic              dbg_req_valid;
  logic [OP_W-1:0]   dbg_req_op;
  logic [DATA_W-1:0] dbg_req_a;
  logic [DATA_W-1:0] dbg_req_b;
  logic              dbg_req_ready;

  logic              cop_start;
  logic [OP_W-1:0]   cop_op;
  logic [DATA_W-1:0] cop_a;
  logic [DATA_W-1:0] cop_b;
  logic              cop_abort;
  logic              cop_done;
  logic              cop_error;
  logic [DATA_W-1:0] cop_result;

  logic              mat_cop_working;
  logic              mat_cop_result_valid;
  logic              mat_cop_error;
  logic [DATA_W-1:0] mat_cop_result;
  logic              result_owner;

  modport slave (
    input  cpu_req_valid, cpu_req_op, cpu_req_a, cpu_req_b,
    output cpu_req_ready,
    input  dbg_req_valid, dbg_req_op, dbg_req_a, dbg_req_b,
    output dbg_req_ready,
    output cop_start, cop_op, cop_a, cop_b, cop_abort,
    input  cop_done, cop_error, cop_result,
    output mat_cop_working, mat_cop_result_valid, mat_cop_error, mat_cop_result, result_owner
  );

  modport master (
    output cpu_req_valid, cpu_req_op, cpu_req_a, cpu_req_b,
    input  cpu_req_ready,
    output dbg_req_valid, dbg_req_op, dbg_req_a, dbg_req_b,
    input  dbg_req_ready,
    input  cop_start, cop_op, cop_a, cop_b, cop_abort,
    output cop_done, cop_error, cop_result,
    input  mat_cop_working, mat_cop_result_valid, mat_cop_error, mat_cop_result, result_owner
  );

endinterface

// File: rtl/mat_cop_rr_arb.sv
// rtl/mat_cop_rr_arb.sv - 2-way round-robin arbiter, bit 0 = CPU, bit 1 = debug
module mat_cop_rr_arb
  import mat_cop_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  // owner granted most recently; reset value makes the CPU win the first tie
  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_last == OWNER_CPU) ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= OWNER_DBG;
    end else if (i_advance && (o_grant != 2'b00)) begin
      r_last <= owner_of(o_grant);
    end
  end

endmodule

// File: rtl/mat_cop_scheduler.sv
// rtl/mat_cop_scheduler.sv - CPU/debug coprocessor scheduler; MAT_COP_TIMEOUT_EN adds a WAIT watchdog
module mat_cop_scheduler
  import mat_cop_scheduler_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OP_W        = OPC_BIT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
  input  logic                clk,
  input  logic                rst,
  mat_cop_scheduler_if.slave  bus
);

  logic [1:0]        r_state;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_owner;
  logic [DATA_W-1:0] r_result;
  logic              r_err;

  logic              w_idle;
  logic [1:0]        w_req_valid;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_timeout;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_req_valid = {bus.dbg_req_valid, bus.cpu_req_valid};
  assign w_accept    = w_idle && (w_grant != 2'b00);

  mat_cop_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (w_req_valid),
    .i_advance (w_idle),
    .o_grant   (w_grant)
  );

  // ready is only offered while idle, so a busy scheduler never accepts
  assign bus.cpu_req_ready = w_idle && w_grant[0];
  assign bus.dbg_req_ready = w_idle && w_grant[1];

`ifdef MAT_COP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_wait_cnt;

  // WAIT is only entered from ISSUE, so clearing there zeroes the count on WAIT entry
  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_ISSUE)) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && !bus.cop_done &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (TIMEOUT_CYC > 1);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_owner  <= OWNER_CPU;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_ISSUE;
            r_owner <= owner_of(w_grant);
            r_op    <= w_grant[1] ? bus.dbg_req_op : bus.cpu_req_op;
            r_a     <= w_grant[1] ? bus.dbg_req_a  : bus.cpu_req_a;
            r_b     <= w_grant[1] ? bus.dbg_req_b  : bus.cpu_req_b;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // completion in the timeout cycle takes priority over the abort
          if (bus.cop_done) begin
            r_state  <= ST_RESP;
            r_result <= bus.cop_result;
            r_err    <= bus.cop_error;
          end else if (w_timeout) begin
            r_state  <= ST_RESP;
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cop_start            = (r_state == ST_ISSUE);
  assign bus.cop_op               = r_op;
  assign bus.cop_a                = r_a;
  assign bus.cop_b                = r_b;
  assign bus.cop_abort            = w_timeout;

  assign bus.mat_cop_working      = !w_idle;
  assign bus.mat_cop_result_valid = (r_state == ST_RESP);
  assign bus.mat_cop_error        = (r_state == ST_RESP) && r_err;
  assign bus.mat_cop_result       = r_result;
  assign bus.result_owner         = (r_state == ST_RESP) && r_owner;

endmodule
